// File: rtl/fp16_dot_ctrl.sv
// Dot-product job sequencer: streams operand pairs through the fp16 multiplier,
// registers each carry-save product for the Kulisch accumulator and reports completion.
module fp16_dot_ctrl #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned EWIDTH = 5,
  parameter int unsigned MWIDTH = 10,
  parameter int unsigned LWIDTH = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     start,
  input  logic [LWIDTH-1:0]        len,
  input  logic                     abort,
  output logic                     busy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DWIDTH-1:0]        in_a,
  input  logic [DWIDTH-1:0]        in_b,
  output logic [DWIDTH-1:0]        mul_a,
  output logic [DWIDTH-1:0]        mul_b,
  input  logic [2*MWIDTH+1:0]      mul_sum,
  input  logic [2*MWIDTH+1:0]      mul_carry,
  input  logic [EWIDTH-1:0]        mul_exponent,
  input  logic                     mul_exception,
  input  logic                     mul_overflow,
  input  logic                     mul_underflow,
  output logic                     acc_clear,
  output logic                     acc_valid,
  output logic                     acc_last,
  output logic                     acc_sign,
  output logic [2*MWIDTH+1:0]      acc_sum,
  output logic [2*MWIDTH+1:0]      acc_carry,
  output logic [EWIDTH-1:0]        acc_exponent,
  output logic                     done,
  output logic [2:0]               err_flags
);

  localparam int unsigned PWIDTH = 2 * MWIDTH + 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [LWIDTH-1:0]   count;
  logic                take;
  logic                take_last;
  logic                zero_start;

  // Multiplier is combinational; operands only reach it while pairs are being accepted.
  assign mul_a = (state == S_RUN) ? in_a : DWIDTH'(0);
  assign mul_b = (state == S_RUN) ? in_b : DWIDTH'(0);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state; abort outranks everything outside IDLE, including a pending handshake.
  always_comb begin
    state_next = state;
    take       = 1'b0;
    take_last  = 1'b0;
    zero_start = 1'b0;
    if (state == S_IDLE) begin
      if (start) begin
        zero_start = (len == LWIDTH'(0));
        state_next = zero_start ? S_DONE : S_CLEAR;
      end
    end else if (abort) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_CLEAR: state_next = S_RUN;
        S_RUN: begin
          take      = in_valid;
          take_last = in_valid && (count == LWIDTH'(1));
          if (take_last) begin
            state_next = S_DRAIN;
          end
        end
        S_DRAIN: state_next = S_DONE;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      busy      <= 1'b0;
      in_ready  <= 1'b0;
      acc_clear <= 1'b0;
      done      <= 1'b0;
      acc_valid <= 1'b0;
      acc_last  <= 1'b0;
    end else begin
      busy      <= (state_next != S_IDLE);
      in_ready  <= (state_next == S_RUN);
      acc_clear <= (state_next == S_CLEAR);
      done      <= (state_next == S_DONE);
      acc_valid <= take;
      acc_last  <= take_last;
    end
  end

  // Product stage, pair counter and sticky error flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      count        <= LWIDTH'(0);
      acc_sign     <= 1'b0;
      acc_sum      <= PWIDTH'(0);
      acc_carry    <= PWIDTH'(0);
      acc_exponent <= EWIDTH'(0);
      err_flags    <= 3'b000;
    end else begin
      if (state == S_IDLE && start) begin
        count <= len;
      end
      if (take) begin
        count        <= count - LWIDTH'(1);
        acc_sign     <= in_a[DWIDTH-1] ^ in_b[DWIDTH-1];
        acc_sum      <= mul_sum;
        acc_carry    <= mul_carry;
        acc_exponent <= mul_exponent;
        err_flags    <= err_flags | {mul_exception, mul_overflow, mul_underflow};
      end
      if ((state == S_CLEAR && !abort) || zero_start) begin
        err_flags <= 3'b000;
      end
    end
  end

endmodule

// File: tb/tb_fp16_dot_ctrl.sv
// Self-checking bench for fp16_dot_ctrl: job-level reference model compared every cycle,
// directed scenarios with literal expectations, then randomized jobs.
module tb_fp16_dot_ctrl;

  localparam int unsigned DW = 16;
  localparam int unsigned EW = 5;
  localparam int unsigned MW = 10;
  localparam int unsigned LW = 8;
  localparam int unsigned PW = 2 * MW + 2;

  localparam int P_IDLE  = 0;
  localparam int P_CLEAR = 1;
  localparam int P_RUN   = 2;
  localparam int P_DRAIN = 3;
  localparam int P_DONE  = 4;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic          start, abort, in_valid;
  logic [LW-1:0] len;
  logic [DW-1:0] in_a, in_b;
  logic [PW-1:0] mul_sum, mul_carry;
  logic [EW-1:0] mul_exponent;
  logic          mul_exception, mul_overflow, mul_underflow;
  logic          busy, in_ready, acc_clear, acc_valid, acc_last, acc_sign, done;
  logic [DW-1:0] mul_a, mul_b;
  logic [PW-1:0] acc_sum, acc_carry;
  logic [EW-1:0] acc_exponent;
  logic [2:0]    err_flags;

  fp16_dot_ctrl #(.DWIDTH(DW), .EWIDTH(EW), .MWIDTH(MW), .LWIDTH(LW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .len(len), .abort(abort), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_sum(mul_sum), .mul_carry(mul_carry),
    .mul_exponent(mul_exponent), .mul_exception(mul_exception),
    .mul_overflow(mul_overflow), .mul_underflow(mul_underflow),
    .acc_clear(acc_clear), .acc_valid(acc_valid), .acc_last(acc_last),
    .acc_sign(acc_sign), .acc_sum(acc_sum), .acc_carry(acc_carry),
    .acc_exponent(acc_exponent), .done(done), .err_flags(err_flags)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: job phase, pairs still owed, last captured product, sticky flags.
  int            m_phase = P_IDLE;
  int            m_left  = 0;
  bit            m_take  = 1'b0;
  bit            m_valid = 1'b0;
  bit            m_last  = 1'b0;
  bit            m_sign  = 1'b0;
  logic [PW-1:0] m_sum   = '0;
  logic [PW-1:0] m_carry = '0;
  logic [EW-1:0] m_exp   = '0;
  logic [2:0]    m_err   = '0;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      m_phase = P_IDLE; m_left = 0; m_valid = 0; m_last = 0; m_sign = 0;
      m_sum = '0; m_carry = '0; m_exp = '0; m_err = '0;
    end else begin
      m_take  = (m_phase == P_RUN) && in_valid && !abort;
      m_valid = m_take;
      m_last  = m_take && (m_left == 1);
      if (m_take) begin
        m_sum   = mul_sum;
        m_carry = mul_carry;
        m_exp   = mul_exponent;
        m_sign  = in_a[DW-1] ^ in_b[DW-1];
        m_err   = m_err | {mul_exception, mul_overflow, mul_underflow};
      end
      if (m_phase != P_IDLE && abort) begin
        m_phase = P_IDLE;
      end else begin
        case (m_phase)
          P_IDLE:
            if (start) begin
              if (len == 0) begin
                m_phase = P_DONE;
                m_err   = '0;
              end else begin
                m_phase = P_CLEAR;
                m_left  = int'(len);
              end
            end
          P_CLEAR: begin m_err = '0; m_phase = P_RUN; end
          P_RUN:
            if (m_take) begin
              m_left = m_left - 1;
              if (m_left == 0) m_phase = P_DRAIN;
            end
          P_DRAIN: m_phase = P_DONE;
          default: m_phase = P_IDLE;
        endcase
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    chk("busy",         busy,         m_phase != P_IDLE);
    chk("in_ready",     in_ready,     m_phase == P_RUN);
    chk("acc_clear",    acc_clear,    m_phase == P_CLEAR);
    chk("done",         done,         m_phase == P_DONE);
    chk("acc_valid",    acc_valid,    m_valid);
    chk("acc_last",     acc_last,     m_last);
    chk("acc_sign",     acc_sign,     m_sign);
    chk("acc_sum",      acc_sum,      m_sum);
    chk("acc_carry",    acc_carry,    m_carry);
    chk("acc_exponent", acc_exponent, m_exp);
    chk("err_flags",    err_flags,    m_err);
    chk("mul_a",        mul_a,        (m_phase == P_RUN) ? in_a : '0);
    chk("mul_b",        mul_b,        (m_phase == P_RUN) ? in_b : '0);
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic quiet();
    start = 0; abort = 0; in_valid = 0; len = '0;
    in_a = '0; in_b = '0; mul_sum = '0; mul_carry = '0; mul_exponent = '0;
    mul_exception = 0; mul_overflow = 0; mul_underflow = 0;
  endtask

  task automatic rnd_pair();
    in_a = DW'($urandom); in_b = DW'($urandom);
    mul_sum = PW'($urandom); mul_carry = PW'($urandom); mul_exponent = EW'($urandom);
    mul_exception = ($urandom_range(0, 15) == 0);
    mul_overflow  = ($urandom_range(0, 15) == 0);
    mul_underflow = ($urandom_range(0, 15) == 0);
  endtask

  int pat[6] = '{1, 0, 1, 1, 0, 1};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;
    int budget;
    quiet();
    #1 RST = 0;
    repeat (3) step();
    chk("rst_busy", busy, 1'b0);
    chk("rst_acc_sum", acc_sum, '0);
    chk("rst_err", err_flags, 3'b000);
    RST = 1;
    step();

    // Single pair with a known product.
    start = 1; len = LW'(1);
    step();
    chk("j1_clear", acc_clear, 1'b1);
    chk("j1_busy_clear", busy, 1'b1);
    start = 0; in_valid = 1; in_a = 16'h3C00; in_b = 16'h4000;
    mul_sum = PW'(22'h100000); mul_carry = '0; mul_exponent = 5'h10;
    step();
    chk("j1_ready", in_ready, 1'b1);
    chk("j1_no_valid_run", acc_valid, 1'b0);
    chk("j1_mul_a", mul_a, 16'h3C00);
    step();
    in_valid = 0;
    chk("j1_valid", acc_valid, 1'b1);
    chk("j1_last", acc_last, 1'b1);
    chk("j1_sum", acc_sum, 22'h100000);
    chk("j1_exp", acc_exponent, 5'h10);
    chk("j1_sign", acc_sign, 1'b0);
    chk("j1_busy_drain", busy, 1'b1);
    step();
    chk("j1_done", done, 1'b1);
    chk("j1_valid_done", acc_valid, 1'b0);
    chk("j1_busy_done", busy, 1'b1);
    step();
    chk("j1_done_end", done, 1'b0);
    chk("j1_busy_end", busy, 1'b0);

    // Four pairs with gaps in in_valid.
    start = 1; len = LW'(4);
    step();
    start = 0;
    step();
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      in_valid = pat[i][0];
      rnd_pair();
      step();
      pulses += int'(acc_valid);
      chk("j2_valid_follow", acc_valid, pat[i][0]);
      chk("j2_last", acc_last, (i == 5));
    end
    in_valid = 0;
    chk("j2_pulses", pulses, 4);
    chk("j2_ready_after", in_ready, 1'b0);
    step();
    chk("j2_done", done, 1'b1);
    step();

    // Overflow on pair 2 and a negative operand on pair 3.
    quiet();
    start = 1; len = LW'(3);
    step();
    start = 0;
    step();
    in_valid = 1; in_a = 16'h3C00; in_b = 16'h3C00;
    step();
    chk("j3_sign1", acc_sign, 1'b0);
    mul_overflow = 1;
    step();
    mul_overflow = 0; in_a = 16'hBC00; in_b = 16'h4000;
    step();
    in_valid = 0;
    chk("j3_sign3", acc_sign, 1'b1);
    chk("j3_last", acc_last, 1'b1);
    step();
    chk("j3_done", done, 1'b1);
    chk("j3_err", err_flags, 3'b010);
    step();
    chk("j3_err_hold", err_flags, 3'b010);

    // Next job clears flags in CLEAR; a start during RUN is ignored.
    start = 1; len = LW'(2);
    step();
    chk("j4_err_in_clear", err_flags, 3'b010);
    start = 0;
    step();
    chk("j4_err_cleared", err_flags, 3'b000);
    in_valid = 1; start = 1; len = LW'(7);
    step();
    step();
    start = 0; in_valid = 0;
    step();
    chk("j4_done", done, 1'b1);
    step();
    chk("j4_idle", busy, 1'b0);

    // Zero-length job.
    start = 1; len = '0;
    step();
    start = 0;
    chk("j5_done", done, 1'b1);
    chk("j5_no_clear", acc_clear, 1'b0);
    step();
    chk("j5_idle", busy, 1'b0);
    chk("j5_no_valid", acc_valid, 1'b0);

    // Abort after two of five pairs, with a pair offered in the abort cycle.
    start = 1; len = LW'(5);
    step();
    start = 0;
    step();
    in_valid = 1; rnd_pair();
    step();
    rnd_pair();
    step();
    abort = 1; rnd_pair();
    step();
    chk("j6_busy", busy, 1'b0);
    chk("j6_no_accept", acc_valid, 1'b0);
    chk("j6_ready", in_ready, 1'b0);
    abort = 0; in_valid = 0;
    step();
    chk("j6_no_done", done, 1'b0);

    // Asynchronous reset in the middle of a job.
    start = 1; len = LW'(6);
    step();
    start = 0;
    step();
    in_valid = 1; rnd_pair(); mul_overflow = 1;
    step();
    step();
    #1 RST = 0;
    #1;
    chk("rst_mid_busy", busy, 1'b0);
    chk("rst_mid_valid", acc_valid, 1'b0);
    chk("rst_mid_sum", acc_sum, '0);
    chk("rst_mid_err", err_flags, 3'b000);
    chk("rst_mid_ready", in_ready, 1'b0);
    RST = 1;
    quiet();
    step();

    // Randomized jobs with handshake gaps, stray starts and aborts.
    for (int j = 0; j < 40; j++) begin
      quiet();
      abort = ($urandom_range(0, 1) == 1);
      step();
      start = 1;
      len = ($urandom_range(0, 7) == 0) ? LW'(0) : LW'($urandom_range(1, 12));
      abort = ($urandom_range(0, 7) == 0);
      in_valid = ($urandom_range(0, 1) == 1);
      rnd_pair();
      step();
      budget = 0;
      while (m_phase != P_IDLE && budget < 200) begin
        start    = ($urandom_range(0, 9) == 0);
        len      = LW'($urandom_range(0, 12));
        abort    = ($urandom_range(0, 39) == 0);
        in_valid = ($urandom_range(0, 3) != 0);
        rnd_pair();
        step();
        budget++;
      end
      if (budget >= 200) begin
        checks++;
        errors++;
        $display("FAIL job_timeout: job %0d still active after %0d cycles", j, budget);
      end
    end

    quiet();
    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
